// File: rtl/bcd_cnt_pkg.sv
// Shared constants and helpers for the BCD modulo counter family.
// The helpers are only meant for elaboration-time constants and for
// simple per-digit range checks; the counting path stays in BCD.
package bcd_cnt_pkg;

  localparam int          BCD_DIGIT_W    = 4;
  localparam logic [3:0]  BCD_MAX        = 4'd9;
  localparam int          BCD_MAX_DIGITS = 8;
  localparam int          BCD_PACK_W     = BCD_DIGIT_W * BCD_MAX_DIGITS;

  typedef logic [BCD_PACK_W-1:0] bcd_pack_t;

  // Binary integer to packed BCD, digit 0 in the low nibble.
  function automatic bcd_pack_t to_bcd(input int value);
    bcd_pack_t r;
    int        v;
    r = '0;
    v = value;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // True when every one of the low 'digits' nibbles holds 0..9.
  function automatic logic bcd_valid(input bcd_pack_t value, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if ((i < digits) && (value[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX))
        ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// One BCD decade of next-value logic: increments or decrements the digit
// when step_in_i is high and reports the decade wrap on ripple_o
// (9 -> 0 going up, 0 -> 9 going down) so the next decade can follow.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       step_in_i,
  input  logic       up_dn_i,
  output logic [3:0] digit_nxt_o,
  output logic       ripple_o
);

  // Combinational decade step with wrap detection.
  always_comb begin
    digit_nxt_o = digit_i;
    ripple_o    = 1'b0;
    if (step_in_i) begin
      if (up_dn_i) begin
        if (digit_i >= BCD_MAX) begin
          digit_nxt_o = 4'd0;
          ripple_o    = 1'b1;
        end else begin
          digit_nxt_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == 4'd0) begin
          digit_nxt_o = BCD_MAX;
          ripple_o    = 1'b1;
        end else begin
          digit_nxt_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with up/down stepping, synchronous load
// and a chainable wrap pulse on carry_out.
// Optional build macro BCD_MOD_COUNTER_SATURATE_EN: the count sticks at
// its end points instead of wrapping and carry_out is tied low.
module bcd_mod_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                carry_in,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                carry_out,
  output logic                load_err
);

  localparam int        W         = BCD_DIGIT_W * DIGITS;
  localparam bcd_pack_t MAX_PACK  = to_bcd(MODULUS - 1);
  localparam logic [W-1:0] MAX_BCD = MAX_PACK[W-1:0];

  if ((DIGITS < 1) || (DIGITS > BCD_MAX_DIGITS) ||
      (MODULUS < 2) || (MODULUS > 10**DIGITS)) begin : g_param_check
    $error("bcd_mod_counter: illegal DIGITS/MODULUS combination");
  end

  logic [W-1:0]  cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [W-1:0]  step_val;
  logic [DIGITS:0] ripple;
  logic          step;
  logic          cnt_ok;
  logic          ld_ok;
  logic          at_max;
  logic          at_zero_dn;
`ifndef BCD_MOD_COUNTER_SATURATE_EN
  logic          carry_q, carry_d;
`endif

  assign step      = en & carry_in;
  assign ripple[0] = step;

  // Decade chain: each digit steps only when every lower digit wrapped.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit_i     (cnt_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .step_in_i   (ripple[g]),
      .up_dn_i     (up_dn),
      .digit_nxt_o (step_val[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .ripple_o    (ripple[g+1])
    );
  end

  // Limit detection works directly on BCD: with legal digits, packed BCD
  // ordering equals decimal ordering, so no conversion is needed.
  assign cnt_ok     = bcd_valid(bcd_pack_t'(cnt_q), DIGITS) && (cnt_q <= MAX_BCD);
  assign ld_ok      = bcd_valid(bcd_pack_t'(load_val), DIGITS) && (load_val <= MAX_BCD);
  assign at_max     = (cnt_q == MAX_BCD);
  // A borrow out of the top decade means every digit was zero.
  assign at_zero_dn = ~up_dn & ripple[DIGITS];

  // Next-state selection: load beats step, step beats hold.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
`ifndef BCD_MOD_COUNTER_SATURATE_EN
    carry_d = 1'b0;
`endif
    if (load) begin
      if (ld_ok) begin
        cnt_d = load_val;
      end else begin
        cnt_d = '0;
        err_d = 1'b1;
      end
    end else if (step) begin
      if (!cnt_ok) begin
        cnt_d = '0;
      end else if (up_dn && at_max) begin
`ifdef BCD_MOD_COUNTER_SATURATE_EN
        cnt_d = cnt_q;
`else
        cnt_d   = '0;
        carry_d = 1'b1;
`endif
      end else if (at_zero_dn) begin
`ifdef BCD_MOD_COUNTER_SATURATE_EN
        cnt_d = cnt_q;
`else
        cnt_d   = MAX_BCD;
        carry_d = 1'b1;
`endif
      end else begin
        cnt_d = step_val;
      end
    end
  end

  // Count and load-error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

`ifdef BCD_MOD_COUNTER_SATURATE_EN
  assign carry_out = 1'b0;
`else
  // Wrap pulse register, aligned with the wrapped count.
  always_ff @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end
  assign carry_out = carry_q;
`endif

  assign bcd_out  = cnt_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Randomised bench for bcd_mod_counter: two instances (mod 60 and mod 24)
// share one stimulus stream and are compared every cycle against an
// integer-valued model, with directed literal expectations in between.
module tb_bcd_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, carry_in, up_dn, load;
  logic [7:0] load_val;
  logic [7:0] bcd60, bcd24;
  logic       co60, co24, le60, le24;

  int n_pass = 0;
  int n_chk  = 0;

  int m60 = 0, m24 = 0;
  bit mc60, me60, mc24, me24;
  bit mvalid = 1'b0;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) dut60 (
    .clk(clk), .rst(rst), .en(en), .carry_in(carry_in), .up_dn(up_dn),
    .load(load), .load_val(load_val), .bcd_out(bcd60), .carry_out(co60),
    .load_err(le60)
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) dut24 (
    .clk(clk), .rst(rst), .en(en), .carry_in(carry_in), .up_dn(up_dn),
    .load(load), .load_val(load_val), .bcd_out(bcd24), .carry_out(co24),
    .load_err(le24)
  );

  always #5 clk = ~clk;

  // Decimal integer to two-digit packed BCD.
  function automatic logic [7:0] to_pk(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Behavioural model of one clock edge, counting in plain integers.
  function automatic void model_edge(input int md, inout int v, output bit c, output bit e);
    int d0, d1;
    c = 1'b0;
    e = 1'b0;
    if (rst) begin
      v = 0;
    end else if (load) begin
      d0 = int'(load_val[3:0]);
      d1 = int'(load_val[7:4]);
      if (d0 <= 9 && d1 <= 9 && (d1 * 10 + d0) < md) v = d1 * 10 + d0;
      else begin
        v = 0;
        e = 1'b1;
      end
    end else if (en && carry_in) begin
      if (up_dn) begin
        if (v == md - 1) begin
`ifdef BCD_MOD_COUNTER_SATURATE_EN
          v = md - 1;
`else
          v = 0;
          c = 1'b1;
`endif
        end else v = v + 1;
      end else begin
        if (v == 0) begin
`ifdef BCD_MOD_COUNTER_SATURATE_EN
          v = 0;
`else
          v = md - 1;
          c = 1'b1;
`endif
        end else v = v - 1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model advances on the same edge the DUT registers.
  always @(posedge clk) begin
    model_edge(60, m60, mc60, me60);
    model_edge(24, m24, mc24, me24);
    if (rst) mvalid = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      check("m60_bcd",   32'(bcd60), 32'(to_pk(m60)));
      check("m60_carry", 32'(co60),  32'(mc60));
      check("m60_err",   32'(le60),  32'(me60));
      check("m24_bcd",   32'(bcd24), 32'(to_pk(m24)));
      check("m24_carry", 32'(co24),  32'(mc24));
      check("m24_err",   32'(le24),  32'(me24));
    end
  end

  // Apply one cycle of inputs; returns after the edge, at the sample point.
  task automatic drive(input bit r, input bit l, input logic [7:0] lv,
                       input bit e, input bit c, input bit u);
    rst = r; load = l; load_val = lv; en = e; carry_in = c; up_dn = u;
    @(negedge clk);
  endtask

  initial begin
    int x;
    rst = 1'b1; load = 1'b0; load_val = 8'h00; en = 1'b0; carry_in = 1'b0; up_dn = 1'b1;

    drive(1, 0, 8'h00, 0, 0, 1);
    check("reset_bcd",   32'(bcd60), 32'h00);
    check("reset_carry", 32'(co60),  32'h0);
    check("reset_err",   32'(le60),  32'h0);

    // Full up sweep.
    for (int i = 1; i <= 60; i++) begin
      drive(0, 0, 8'h00, 1, 1, 1);
      if (i == 23) check("m24_at23", 32'(bcd24), 32'h23);
      if (i == 24) begin
`ifdef BCD_MOD_COUNTER_SATURATE_EN
        check("m24_sat_top", 32'(bcd24), 32'h23);
        check("m24_sat_co",  32'(co24),  32'h0);
`else
        check("m24_wrap",    32'(bcd24), 32'h00);
        check("m24_wrap_co", 32'(co24),  32'h1);
`endif
      end
      if (i == 59) begin
        check("m60_at59",    32'(bcd60), 32'h59);
        check("m60_at59_co", 32'(co60),  32'h0);
      end
      if (i == 60) begin
`ifdef BCD_MOD_COUNTER_SATURATE_EN
        check("m60_sat_top", 32'(bcd60), 32'h59);
        check("m60_sat_co",  32'(co60),  32'h0);
`else
        check("m60_wrap",    32'(bcd60), 32'h00);
        check("m60_wrap_co", 32'(co60),  32'h1);
`endif
      end
    end

    // Down from zero, then down across a decade.
    drive(0, 1, 8'h00, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 0);
`ifdef BCD_MOD_COUNTER_SATURATE_EN
    check("dn_zero_sat",    32'(bcd60), 32'h00);
    check("dn_zero_sat_co", 32'(co60),  32'h0);
`else
    check("dn_zero_wrap",   32'(bcd60), 32'h59);
    check("dn_zero_co",     32'(co60),  32'h1);
`endif
    drive(0, 1, 8'h10, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 0);
    check("dn_10_to_09", 32'(bcd60), 32'h09);
    check("dn_10_co",    32'(co60),  32'h0);

    // Loads: valid, bad digit, out of range.
    drive(0, 1, 8'h45, 0, 0, 1);
    check("load45_bcd", 32'(bcd60), 32'h45);
    check("load45_err", 32'(le60),  32'h0);
    check("load45_m24", 32'(le24),  32'h1);
    drive(0, 1, 8'h6A, 0, 0, 1);
    check("load6A_bcd", 32'(bcd60), 32'h00);
    check("load6A_err", 32'(le60),  32'h1);
    drive(0, 1, 8'h60, 0, 0, 1);
    check("load60_bcd", 32'(bcd60), 32'h00);
    check("load60_err", 32'(le60),  32'h1);

    // Holds.
    drive(0, 1, 8'h37, 0, 0, 1);
    drive(0, 0, 8'h00, 0, 1, 1);
    check("hold_en0", 32'(bcd60), 32'h37);
    drive(0, 0, 8'h00, 1, 0, 1);
    check("hold_ci0", 32'(bcd60), 32'h37);

    // Load wins over a wrapping step.
    drive(0, 1, 8'h59, 0, 0, 1);
    drive(0, 1, 8'h30, 1, 1, 1);
    check("load_vs_step_bcd", 32'(bcd60), 32'h30);
    check("load_vs_step_co",  32'(co60),  32'h0);

    // Mod 24 wrap from 23.
    drive(0, 1, 8'h23, 0, 0, 1);
    drive(0, 0, 8'h00, 1, 1, 1);
    check("m60_23_to_24", 32'(bcd60), 32'h24);
`ifdef BCD_MOD_COUNTER_SATURATE_EN
    check("m24_23_sat", 32'(bcd24), 32'h23);
`else
    check("m24_23_wrap",    32'(bcd24), 32'h00);
    check("m24_23_wrap_co", 32'(co24),  32'h1);
`endif

    // Reset overrides load and step.
    drive(1, 1, 8'h30, 1, 1, 1);
    check("rst_ovr_bcd", 32'(bcd60), 32'h00);
    check("rst_ovr_co",  32'(co60),  32'h0);
    check("rst_ovr_err", 32'(le60),  32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      x = int'($urandom_range(0, 59));
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) ? to_pk(x) : 8'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
